// File: rtl/sprite_fetch_sched_if.sv
// Bundles the pixel stream, sprite ROM, compositor output and collision-query signals
// of sprite_fetch_sched; master drives pixels/ROM data/queries, slave is the scheduler.
interface sprite_fetch_sched_if;
  logic       pix_valid;
  logic [9:0] draw_x;
  logic [9:0] draw_y;
  logic [9:0] mario_x;
  logic [9:0] mario_y;
  logic [9:0] block_x;
  logic [9:0] block_y;
  logic [9:0] coin_x;
  logic [9:0] coin_y;
  logic       coin_en;
  logic [9:0] mario_addr;
  logic [9:0] block_addr;
  logic [9:0] coin_addr;
  logic [2:0] mario_q;
  logic [1:0] block_q;
  logic [1:0] coin_q;
  logic       out_valid;
  logic [1:0] out_layer;
  logic [2:0] out_color;
  logic       q_req;
  logic [9:0] q_x;
  logic [9:0] q_y;
  logic       q_gnt;
  logic       q_done;
  logic       q_hit;

  modport master (
    output pix_valid, draw_x, draw_y, mario_x, mario_y, block_x, block_y, coin_x, coin_y,
    output coin_en, mario_q, block_q, coin_q, q_req, q_x, q_y,
    input  mario_addr, block_addr, coin_addr, out_valid, out_layer, out_color,
    input  q_gnt, q_done, q_hit
  );

  modport slave (
    input  pix_valid, draw_x, draw_y, mario_x, mario_y, block_x, block_y, coin_x, coin_y,
    input  coin_en, mario_q, block_q, coin_q, q_req, q_x, q_y,
    output mario_addr, block_addr, coin_addr, out_valid, out_layer, out_color,
    output q_gnt, q_done, q_hit
  );
endinterface

// File: rtl/sprite_fetch_sched.sv
// Per-pixel sprite ROM fetch, three-layer compositor and idle-slot block-ROM query port.
// The coin layer is compiled in only when SPRITE_COIN_EN is defined.
module sprite_fetch_sched #(
  parameter int unsigned MARIO_W = 26,
  parameter int unsigned MARIO_H = 32,
  parameter int unsigned BLOCK_W = 32,
  parameter int unsigned BLOCK_H = 32,
  parameter int unsigned COIN_W  = 28,
  parameter int unsigned COIN_H  = 32
) (
  input logic                 clk,
  input logic                 reset_n,
  sprite_fetch_sched_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  localparam logic [10:0] MarioW = 11'(MARIO_W);
  localparam logic [10:0] MarioH = 11'(MARIO_H);
  localparam logic [10:0] BlockW = 11'(BLOCK_W);
  localparam logic [10:0] BlockH = 11'(BLOCK_H);

  // 11-bit compares so objects near the right/bottom edge never wrap back to 0.
  function automatic logic obj_hit(input logic [9:0] px, input logic [9:0] py,
                                   input logic [9:0] ox, input logic [9:0] oy,
                                   input logic [10:0] w, input logic [10:0] h);
    logic [10:0] x, y, x0, y0;
    x  = {1'b0, px};
    y  = {1'b0, py};
    x0 = {1'b0, ox};
    y0 = {1'b0, oy};
    return (x >= x0) && (x < x0 + w) && (y >= y0) && (y < y0 + h);
  endfunction

  function automatic logic [9:0] obj_addr(input logic [9:0] px, input logic [9:0] py,
                                          input logic [9:0] ox, input logic [9:0] oy,
                                          input logic [9:0] w);
    logic [9:0] dx, dy, prod;
    dx   = px - ox;
    dy   = py - oy;
    prod = dy * w;
    return prod + dx;
  endfunction

  // S0: hit tests and address generation
  logic       m_hit, b_hit, qry_hit;
  logic [9:0] m_addr, b_addr, qry_addr;

  always_comb begin
    m_hit    = obj_hit(bus.draw_x, bus.draw_y, bus.mario_x, bus.mario_y, MarioW, MarioH);
    m_addr   = m_hit ? obj_addr(bus.draw_x, bus.draw_y, bus.mario_x, bus.mario_y,
                                MarioW[9:0]) : '0;
    b_hit    = obj_hit(bus.draw_x, bus.draw_y, bus.block_x, bus.block_y, BlockW, BlockH);
    b_addr   = b_hit ? obj_addr(bus.draw_x, bus.draw_y, bus.block_x, bus.block_y,
                                BlockW[9:0]) : '0;
    qry_hit  = obj_hit(bus.q_x, bus.q_y, bus.block_x, bus.block_y, BlockW, BlockH);
    qry_addr = qry_hit ? obj_addr(bus.q_x, bus.q_y, bus.block_x, bus.block_y,
                                  BlockW[9:0]) : '0;
  end

  // Query FSM state and result registers
  state_e state_q, state_d;
  logic   qry_hit_q, res_pend_q, res_hit_q, q_done_q, q_hit_q;
  logic   accept;

  // A result still in flight blocks re-acceptance until the edge after q_done.
  assign accept = (state_q == StIdle) && bus.q_req && !bus.pix_valid && !res_pend_q;

  // S1/S2 pixel pipeline
  logic       v1_q, mh1_q, bh1_q, v2_q, mh2_q, bh2_q;
  logic [9:0] mario_addr_q, block_addr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q         <= 1'b0;
      mh1_q        <= 1'b0;
      bh1_q        <= 1'b0;
      v2_q         <= 1'b0;
      mh2_q        <= 1'b0;
      bh2_q        <= 1'b0;
      mario_addr_q <= '0;
      block_addr_q <= '0;
    end else begin
      v1_q  <= bus.pix_valid;
      mh1_q <= bus.pix_valid & m_hit;
      bh1_q <= bus.pix_valid & b_hit;
      v2_q  <= v1_q;
      mh2_q <= mh1_q;
      bh2_q <= bh1_q;
      if (bus.pix_valid) begin
        mario_addr_q <= m_addr;
      end
      if (accept) begin
        block_addr_q <= qry_addr;
      end else if (bus.pix_valid) begin
        block_addr_q <= b_addr;
      end
    end
  end

`ifdef SPRITE_COIN_EN
  localparam logic [10:0] CoinW = 11'(COIN_W);
  localparam logic [10:0] CoinH = 11'(COIN_H);

  logic       c_hit, ch1_q, ch2_q;
  logic [9:0] c_addr, coin_addr_q;

  always_comb begin
    c_hit  = bus.coin_en && obj_hit(bus.draw_x, bus.draw_y, bus.coin_x, bus.coin_y,
                                    CoinW, CoinH);
    c_addr = c_hit ? obj_addr(bus.draw_x, bus.draw_y, bus.coin_x, bus.coin_y,
                              CoinW[9:0]) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch1_q       <= 1'b0;
      ch2_q       <= 1'b0;
      coin_addr_q <= '0;
    end else begin
      ch1_q <= bus.pix_valid & c_hit;
      ch2_q <= ch1_q;
      if (bus.pix_valid) begin
        coin_addr_q <= c_addr;
      end
    end
  end

  assign bus.coin_addr = coin_addr_q;
`else
  logic unused_coin;
  assign unused_coin   = ^{bus.coin_q, bus.coin_en, bus.coin_x, bus.coin_y,
                           11'(COIN_W), 11'(COIN_H)};
  assign bus.coin_addr = '0;
`endif

  // Compositor: Mario > coin > block > background, ROM value 0 is transparent
  logic       out_valid_q;
  logic [1:0] layer_d, out_layer_q;
  logic [2:0] color_d, out_color_q;

  always_comb begin
    layer_d = 2'd0;
    color_d = 3'd0;
    if (v2_q) begin
      if (mh2_q && (bus.mario_q != 3'd0)) begin
        layer_d = 2'd3;
        color_d = bus.mario_q;
      end
`ifdef SPRITE_COIN_EN
      else if (ch2_q && (bus.coin_q != 2'd0)) begin
        layer_d = 2'd2;
        color_d = {1'b0, bus.coin_q};
      end
`endif
      else if (bh2_q && (bus.block_q != 2'd0)) begin
        layer_d = 2'd1;
        color_d = {1'b0, bus.block_q};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_layer_q <= 2'd0;
      out_color_q <= 3'd0;
    end else begin
      out_valid_q <= v2_q;
      out_layer_q <= layer_d;
      out_color_q <= color_d;
    end
  end

  // Query FSM: state register / next state / outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.q_gnt = (state_q == StIssue);
  end

  // Block ROM returns the query word during WAIT; result surfaces one cycle after IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      qry_hit_q  <= 1'b0;
      res_pend_q <= 1'b0;
      res_hit_q  <= 1'b0;
      q_done_q   <= 1'b0;
      q_hit_q    <= 1'b0;
    end else begin
      if (accept) begin
        qry_hit_q <= qry_hit;
      end
      res_pend_q <= (state_q == StWait);
      if (state_q == StWait) begin
        res_hit_q <= qry_hit_q && (bus.block_q != 2'd0);
      end
      q_done_q <= res_pend_q;
      q_hit_q  <= res_pend_q & res_hit_q;
    end
  end

  assign bus.mario_addr = mario_addr_q;
  assign bus.block_addr = block_addr_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_layer  = out_layer_q;
  assign bus.out_color  = out_color_q;
  assign bus.q_done     = q_done_q;
  assign bus.q_hit      = q_hit_q;

endmodule

// File: tb/tb_sprite_fetch_sched.sv
// Scoreboard bench for sprite_fetch_sched: a rectangle/priority reference model feeds
// expectation queues that an edge-offset monitor drains against the DUT outputs.
module tb_sprite_fetch_sched;

  localparam int MW = 26;
  localparam int MH = 32;
  localparam int BW = 32;
  localparam int BH = 32;
  localparam int CW = 28;
  localparam int CH = 32;
`ifdef SPRITE_COIN_EN
  localparam bit CoinOn = 1'b1;
`else
  localparam bit CoinOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  sprite_fetch_sched_if bus ();

  sprite_fetch_sched #(
    .MARIO_W(MW), .MARIO_H(MH), .BLOCK_W(BW), .BLOCK_H(BH), .COIN_W(CW), .COIN_H(CH)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Synchronous sprite ROMs
  logic [2:0] mrom [1024];
  logic [1:0] brom [1024];
  logic [1:0] crom [1024];

  always @(posedge clk) begin
    bus.mario_q <= mrom[bus.mario_addr];
    bus.block_q <= brom[bus.block_addr];
    bus.coin_q  <= crom[bus.coin_addr];
  end

  typedef struct { int due; int ma; int ba; int ca; } addr_t;
  typedef struct { int due; int layer; int color; } pix_t;
  typedef struct { int addr; int hit; int gcyc; } qry_t;

  addr_t aq[$];
  pix_t  pq[$];
  qry_t  qq[$];

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int pmx, pmy, pbx, pby, pcx, pcy;
  bit pcen;

  task automatic chk(input string name, input int got, input int want);
    nchk++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic bit inside_obj(int x, int y, int ox, int oy, int w, int h);
    return (x >= ox) && (x < ox + w) && (y >= oy) && (y < oy + h);
  endfunction

  function automatic int offset(int x, int y, int ox, int oy, int w);
    return ((y - oy) * w + (x - ox)) % 1024;
  endfunction

  // Monitor: samples 1 time unit after each rising edge
  logic  pv_e, rq_e;
  logic  gnt_prev = 1'b0;
  addr_t a_e;
  pix_t  p_e;
  qry_t  q_e;

  always @(posedge clk) begin
    pv_e = bus.pix_valid;
    rq_e = bus.q_req;
    cyc++;
    #1;
    if (reset_n) begin
      if (aq.size() > 0 && aq[0].due == cyc) begin
        a_e = aq.pop_front();
        chk("mario_addr", int'(bus.mario_addr), a_e.ma);
        chk("block_addr", int'(bus.block_addr), a_e.ba);
        chk("coin_addr", int'(bus.coin_addr), a_e.ca);
      end
      if (pq.size() > 0 && pq[0].due == cyc) begin
        p_e = pq.pop_front();
        chk("out_valid", int'(bus.out_valid), 1);
        chk("out_layer", int'(bus.out_layer), p_e.layer);
        chk("out_color", int'(bus.out_color), p_e.color);
      end else begin
        chk("out_valid_idle", int'(bus.out_valid), 0);
      end
      if (bus.q_gnt && !gnt_prev) begin
        chk("gnt_needs_idle_pixel", int'(pv_e), 0);
        chk("gnt_needs_req", int'(rq_e), 1);
        chk("queries_pending_at_gnt", qq.size(), 1);
        if (qq.size() > 0) begin
          q_e = qq[0];
          chk("query_block_addr", int'(bus.block_addr), q_e.addr);
          q_e.gcyc = cyc;
          qq[0] = q_e;
        end
      end else if (gnt_prev) begin
        chk("gnt_pulse_width", int'(bus.q_gnt), 0);
      end
      if (bus.q_done) begin
        chk("queries_pending_at_done", qq.size(), 1);
        if (qq.size() > 0) begin
          q_e = qq.pop_front();
          chk("q_done_latency", cyc - q_e.gcyc, 3);
          chk("q_hit", int'(bus.q_hit), q_e.hit);
        end
      end else if (qq.size() > 0 && qq[0].gcyc >= 0 && cyc - qq[0].gcyc > 3) begin
        q_e = qq.pop_front();
        chk("q_done_missing", int'(bus.q_done), 1);
      end
    end
    gnt_prev = bus.q_gnt;
  end

  task automatic set_pos(int mx, int my, int bx, int by, int cx, int cy, bit cen);
    pmx = mx; pmy = my; pbx = bx; pby = by; pcx = cx; pcy = cy; pcen = cen;
    bus.mario_x = 10'(mx); bus.mario_y = 10'(my);
    bus.block_x = 10'(bx); bus.block_y = 10'(by);
    bus.coin_x  = 10'(cx); bus.coin_y  = 10'(cy);
    bus.coin_en = cen;
  endtask

  // Drive one valid pixel for a cycle and queue its expected addresses and output.
  task automatic send_pix(int x, int y);
    bit hm, hb, hc;
    int am, ab, ac, l, c;
    hm = inside_obj(x, y, pmx, pmy, MW, MH);
    hb = inside_obj(x, y, pbx, pby, BW, BH);
    hc = CoinOn && pcen && inside_obj(x, y, pcx, pcy, CW, CH);
    am = hm ? offset(x, y, pmx, pmy, MW) : 0;
    ab = hb ? offset(x, y, pbx, pby, BW) : 0;
    ac = hc ? offset(x, y, pcx, pcy, CW) : 0;
    l = 0;
    c = 0;
    if (hm && mrom[am] != 0) begin
      l = 3; c = int'(mrom[am]);
    end else if (hc && crom[ac] != 0) begin
      l = 2; c = int'(crom[ac]);
    end else if (hb && brom[ab] != 0) begin
      l = 1; c = int'(brom[ab]);
    end
    aq.push_back('{cyc + 1, am, ab, ac});
    pq.push_back('{cyc + 3, l, c});
    bus.pix_valid = 1'b1;
    bus.draw_x = 10'(x);
    bus.draw_y = 10'(y);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    bus.pix_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic int near(int base);
    return (base + $urandom_range(0, 40) - 4) & 1023;
  endfunction

  task automatic send_rand_pix();
    int sel;
    sel = $urandom_range(0, 2);
    if (sel == 0) send_pix(near(pmx), near(pmy));
    else if (sel == 1) send_pix(near(pbx), near(pby));
    else send_pix(near(pcx), near(pcy));
  endtask

  // Hold q_req (with `busy` cycles of pixel traffic first) until granted, then await q_done.
  task automatic do_query(int qx, int qy, int busy);
    int a, n;
    bit h, got;
    h = inside_obj(qx, qy, pbx, pby, BW, BH);
    a = h ? offset(qx, qy, pbx, pby, BW) : 0;
    qq.push_back('{a, int'(h && brom[a] != 0), -1});
    bus.q_req = 1'b1;
    bus.q_x = 10'(qx);
    bus.q_y = 10'(qy);
    n = 0;
    got = 1'b0;
    while (n < 64 && !got) begin
      if (n < busy) send_rand_pix();
      else idle(1);
      n++;
      got = bus.q_gnt;
    end
    chk("q_gnt_wait_cycles", n, busy + 1);
    bus.q_req = 1'b0;
    n = 0;
    while (qq.size() > 0 && n < 12) begin
      if ($urandom_range(0, 1) == 1) send_rand_pix();
      else idle(1);
      n++;
    end
    chk("q_done_timeout", qq.size(), 0);
    qq.delete();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_addrs", int'(bus.mario_addr | bus.block_addr | bus.coin_addr), 0);
    chk("rst_pixel_out", int'({bus.out_valid, bus.out_layer, bus.out_color}), 0);
    chk("rst_query_out", int'({bus.q_gnt, bus.q_done, bus.q_hit}), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mrom[i] = 3'($urandom_range(0, 7));
      brom[i] = 2'($urandom_range(0, 3));
      crom[i] = 2'($urandom_range(0, 3));
    end
    bus.pix_valid = 1'b0;
    bus.draw_x = '0;
    bus.draw_y = '0;
    bus.q_req = 1'b0;
    bus.q_x = '0;
    bus.q_y = '0;
    set_pos(100, 200, 600, 600, 700, 700, 1'b1);
    #1 reset_n = 1'b0;
    #2 chk_reset_outputs();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    // Mario corners and right-edge miss
    mrom[0] = 3'd5;
    mrom[831] = 3'd6;
    send_pix(100, 200);
    send_pix(125, 231);
    send_pix(126, 200);
    send_pix(100, 232);
    idle(4);

    // Objects hanging past the screen edge must not wrap
    set_pos(1010, 1000, 1000, 1010, 1005, 1005, 1'b1);
    send_pix(3, 1005);
    send_pix(1023, 1023);
    send_pix(1010, 1000);
    send_pix(2, 2);
    idle(4);

    // Overlap: Mario transparent, coin then block underneath
    mrom[0] = 3'd0;
    crom[0] = 2'd2;
    brom[0] = 2'd1;
    set_pos(50, 50, 50, 50, 50, 50, 1'b1);
    send_pix(50, 50);
    set_pos(50, 50, 50, 50, 50, 50, 1'b0);
    send_pix(50, 50);
    idle(4);

    // Queries: in blanking, out of bounds, contention with 5 pixel cycles
    set_pos(100, 200, 64, 400, 300, 300, 1'b1);
    brom[326] = 2'd3;
    do_query(70, 410, 0);
    do_query(10, 10, 0);
    do_query(70, 410, 5);
    idle(4);

    // Reset during WAIT drops the query
    qq.push_back('{326, 1, -1});
    bus.q_req = 1'b1;
    bus.q_x = 10'd70;
    bus.q_y = 10'd410;
    idle(1);
    chk("gnt_before_reset", int'(bus.q_gnt), 1);
    bus.q_req = 1'b0;
    idle(1);
    #2 reset_n = 1'b0;
    aq.delete();
    pq.delete();
    qq.delete();
    #1 chk_reset_outputs();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(6);
    do_query(70, 410, 0);

    // Randomised traffic with moving objects and interleaved queries
    for (int i = 0; i < 500; i++) begin
      int r;
      if ($urandom_range(0, 15) == 0) begin
        set_pos($urandom_range(0, 1023), $urandom_range(0, 1023),
                $urandom_range(0, 1023), $urandom_range(0, 1023),
                $urandom_range(0, 1023), $urandom_range(0, 1023),
                1'($urandom_range(0, 1)));
      end
      r = $urandom_range(0, 11);
      if (r < 8) send_rand_pix();
      else if (r < 10) idle(1);
      else begin
        do_query(near(pbx), near(pby), $urandom_range(0, 4));
      end
    end
    idle(8);
    chk("leftover_expectations", aq.size() + pq.size() + qq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/sprite_fetch_sched.md
# sprite_fetch_sched

Per-pixel sprite fetch scheduler and compositor between the VGA pixel stream and the Mario, block and coin sprite ROMs. For each valid pixel it does four things:
- bounds-checks the pixel against each object,
- drives the ROM addresses,
- absorbs the one-cycle ROM read latency,
- selects the top non-transparent layer.

It also shares the block ROM with a low-priority collision-query requester, which is served only in cycles with no pixel traffic.

## Interface
Parameters:
- MARIO_W, 26, Mario sprite width (pixels)
- MARIO_H, 32, Mario sprite height
- BLOCK_W, 32, block width
- BLOCK_H, 32, block height
- COIN_W, 28, coin width
- COIN_H, 32, coin height

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- pix_valid  in  1  draw_x/draw_y valid this cycle
- draw_x, draw_y  in  10 each  current pixel
- mario_x, mario_y, block_x, block_y, coin_x, coin_y  in  10 each  object top-left corners
- coin_en  in  1  coin visible
- mario_addr, block_addr, coin_addr  out  10 each  ROM addresses (registered)
- mario_q  in  3  Mario ROM data
- block_q, coin_q  in  2 each  block/coin ROM data
- out_valid  out  1  composited pixel valid
- out_layer  out  2  0=background, 1=block, 2=coin, 3=Mario
- out_color  out  3  palette index (zero-extended for 2-bit layers)
- q_req  in  1  collision query request
- q_x, q_y  in  10 each  query coordinates
- q_gnt  out  1  query accepted (1-cycle pulse)
- q_done  out  1  query result valid (1-cycle pulse)
- q_hit  out  1  query point is solid block

## Operation
- **Hit test** per object: x ≥ ox and x < ox+W, and y ≥ oy and y < oy+H.
  - Compare in 11 bits, so no wrap.
  - The coin hit additionally requires coin_en.
- **Address**: (y−oy)·W + (x−ox), truncated to 10 bits. On a miss the address is driven 0.
- **Pipeline** (pixel path):
  - S0: hit test, address compute.
  - S1: addresses registered; hit flags and valid registered.
  - S2: ROM q available; the compositor registers out_*.
- **Transparency**: ROM value 0 is transparent. Priority is Mario > coin > block > background.
  - With no opaque hit: out_layer=0, out_color=0.
- **Query FSM**, states IDLE → ISSUE → WAIT → IDLE.
  - IDLE → ISSUE at an edge with q_req=1, pix_valid=0.
    - block_addr loads the query address; q_x/q_y are sampled.
    - The query hit flag is stored.
    - q_gnt=1 during ISSUE.
  - ISSUE → WAIT unconditionally; the ROM latches query data.
  - WAIT → IDLE: q_hit = stored_hit and (block_q≠0), registered; q_done=1 during the following cycle.
- **Pixel priority**: pix_valid=1 blocks acceptance. q_req must be held until q_gnt.
  - Pixel traffic during ISSUE/WAIT is legal. The pixel address loads at the next edge, after the ROM has captured the query address.
- **Out-of-bounds query**: completes normally with q_hit=0.
- **Back-to-back queries**: earliest re-accept is the edge after q_done.

## Timing
- **Pixel latency**: pix_valid at cycle N → out_valid at cycle N+3, fully pipelined, one pixel per cycle.
- **Query**:
  - Accept edge E; q_gnt high during cycle E..E+1.
  - q_done and q_hit valid during cycle E+3..E+4.
- **Reset**: on reset_n=0, immediately:
  - all outputs 0;
  - FSM IDLE;
  - pipeline valids cleared.
- **Reset mid-query**: the query is dropped and no q_done is issued. The requester re-requests.
- **Mid-pixel position change**: object positions are sampled only in S0 and are not held through the pipeline. Changes take effect on the next sampled pixel.

## Configuration
- SPRITE_COIN_EN:
  - Defined: coin layer compiled in as specified.
  - Undefined: coin hit logic is removed and coin_addr is tied 0. coin_q and coin_en are ignored, and out_layer never equals 2.

## Test plan
- **Mario at (100,200), corner pixels**:
  - pix (100,200) → mario_addr=0 at N+1.
  - mario_q=5 → out_layer=3, out_color=5 at N+3.
  - pix (125,231) → mario_addr=831.
- **Right-edge miss**: Mario at (100,200), pix (126,200) → mario_addr=0, out_layer=0, out_color=0.
- **Overlap**: Mario, coin and block all at (50,50), pix (50,50).
  - mario_q=0, coin_q=2, block_q=1 → out_layer=2, out_color=2.
  - With coin_en=0 → out_layer=1, out_color=1.
- **Query in blanking**: block at (64,400), q_req with (70,410), pix_valid=0.
  - block_addr=326 during ISSUE; q_gnt pulse.
  - block_q=3 → q_done, q_hit=1 three cycles after accept.
- **Query contention**: q_req held while pix_valid=1 for 5 cycles → no q_gnt until the first edge with pix_valid=0. The pixel outputs stay uncorrupted throughout.
- **Reset mid-query**: reset_n low during WAIT → q_done never pulses; all outputs 0 immediately. After release, q_req is served normally.
